// File: rtl/hk_spi_pkg.sv
// Shared types and constants for the housekeeping SPI sequencer.
// INIT_TABLE holds the ADC register writes replayed after reset, as {h16, l16}.
package hk_spi_pkg;

    typedef enum logic [2:0] {
        ST_INIT_LD  = 3'd0,
        ST_ARM      = 3'd1,
        ST_WAIT_ACK = 3'd2,
        ST_WAIT_END = 3'd3,
        ST_IDLE     = 3'd4
    } hk_state_e;

    localparam int INIT_MAX = 4;
    localparam int IDX_W    = $clog2(INIT_MAX);
    localparam int RD_BIT   = 15;

    // The top's INIT_N selects how many leading entries are replayed (INIT_N <= INIT_MAX).
    localparam logic [31:0] INIT_TABLE [INIT_MAX] = '{
        32'h0001_003C,
        32'h0014_0001,
        32'h0020_0003,
        32'h0021_0080
    };

endpackage

// File: rtl/hk_spi_wdog.sv
// Transfer watchdog: up-counter cleared on each phase start; hit marks the edge
// on which the elapsed count reaches the limit.
module hk_spi_wdog #(
    parameter int W = 16
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         clr_i,
    input  logic         en_i,
    input  logic [W-1:0] limit_i,
    output logic         hit_o
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && (cnt_q != '1)) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // The count advancing on this edge would equal the limit.
    assign hit_o = en_i && (cnt_q >= (limit_i - W'(1)));

endmodule

// File: rtl/hk_spi_seq.sv
// Replays the ADC init table through spi_master after reset, then serves host
// SPI transactions over valid/ready, with a watchdog on every transfer.
//
// state    | meaning
// INIT_LD  | load next init table entry into the write words
// ARM      | one-cycle start pulse to spi_master
// WAIT_ACK | waiting for spi_busy_i to rise (ACK_TO limit)
// WAIT_END | waiting for spi_busy_i to fall (END_TO limit)
// IDLE     | ready for a host request
module hk_spi_seq
    import hk_spi_pkg::*;
#(
    parameter int INIT_N = 4,
    parameter int ACK_TO = 16,
    parameter int END_TO = 20000,
    parameter int TO_W   = 16
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_valid_i,
    input  logic [15:0] req_h_i,
    input  logic [15:0] req_l_i,
    output logic        req_ready_o,
    output logic        rsp_valid_o,
    output logic [15:0] rsp_data_o,
    output logic        rsp_err_o,
    output logic        init_done_o,
    output logic        err_o,
    output logic        spi_start_o,
    output logic [15:0] spi_wr_h_o,
    output logic [15:0] spi_wr_l_o,
    input  logic [15:0] spi_rd_l_i,
    input  logic        spi_busy_i
);

    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'((INIT_N > 0) ? INIT_N - 1 : 0);
    localparam logic [TO_W-1:0]  ACK_LIM  = TO_W'(ACK_TO);
    localparam logic [TO_W-1:0]  END_LIM  = TO_W'(END_TO);

    hk_state_e        state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [15:0]      wr_h_q, wr_h_d, wr_l_q, wr_l_d;
    logic             start_q, start_d;
    logic             ready_q, ready_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic [15:0]      rsp_data_q, rsp_data_d;
    logic             rsp_err_q, rsp_err_d;
    logic             init_done_q, init_done_d;
    logic             err_q, err_d;

    logic             wd_clr, wd_en, wd_hit;
    logic [TO_W-1:0]  wd_limit;
    logic             xfer_ok, xfer_to;

    assign wd_limit = (state_q == ST_WAIT_END) ? END_LIM : ACK_LIM;

    hk_spi_wdog #(.W(TO_W)) u_wdog (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .clr_i   (wd_clr),
        .en_i    (wd_en),
        .limit_i (wd_limit),
        .hit_o   (wd_hit)
    );

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        wr_h_d      = wr_h_q;
        wr_l_d      = wr_l_q;
        rsp_valid_d = 1'b0;
        rsp_data_d  = rsp_data_q;
        rsp_err_d   = rsp_err_q;
        init_done_d = init_done_q;
        err_d       = err_q;
        wd_en       = 1'b0;
        wd_clr      = 1'b0;
        xfer_ok     = 1'b0;
        xfer_to     = 1'b0;

        case (state_q)
            ST_INIT_LD: begin
                if (INIT_N == 0) begin
                    init_done_d = 1'b1;
                    state_d     = ST_IDLE;
                end else begin
                    {wr_h_d, wr_l_d} = INIT_TABLE[idx_q];
                    state_d          = ST_ARM;
                end
            end
            ST_IDLE: begin
                if (req_valid_i && ready_q) begin
                    wr_h_d  = req_h_i;
                    wr_l_d  = req_l_i;
                    state_d = ST_ARM;
                end
            end
            ST_ARM: begin
                wd_en   = 1'b1;
                state_d = ST_WAIT_ACK;
            end
            ST_WAIT_ACK: begin
                wd_en = 1'b1;
                if (spi_busy_i) begin
                    wd_clr  = 1'b1;
                    state_d = ST_WAIT_END;
                end else if (wd_hit) begin
                    xfer_to = 1'b1;
                end
            end
            ST_WAIT_END: begin
                wd_en = 1'b1;
                if (!spi_busy_i) begin
                    xfer_ok = 1'b1;
                end else if (wd_hit) begin
                    xfer_to = 1'b1;
                end
            end
            default: state_d = ST_INIT_LD;
        endcase

        // A timed-out init entry is skipped and the table advances as usual.
        if (xfer_ok || xfer_to) begin
            if (xfer_to) begin
                err_d = 1'b1;
            end
            if (!init_done_q) begin
                idx_d = idx_q + IDX_W'(1);
                if (idx_q == IDX_LAST) begin
                    init_done_d = 1'b1;
                    state_d     = ST_IDLE;
                end else begin
                    state_d = ST_INIT_LD;
                end
            end else begin
                rsp_valid_d = 1'b1;
                rsp_err_d   = xfer_to;
                rsp_data_d  = xfer_to ? 16'h0000 : spi_rd_l_i;
                state_d     = ST_IDLE;
            end
        end

        if (state_d == ST_ARM) begin
            wd_clr = 1'b1;
        end
        start_d = (state_d == ST_ARM);
        ready_d = (state_d == ST_IDLE);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= ST_INIT_LD;
            idx_q       <= '0;
            wr_h_q      <= '0;
            wr_l_q      <= '0;
            start_q     <= 1'b0;
            ready_q     <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b0;
            init_done_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            wr_h_q      <= wr_h_d;
            wr_l_q      <= wr_l_d;
            start_q     <= start_d;
            ready_q     <= ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_err_q   <= rsp_err_d;
            init_done_q <= init_done_d;
            err_q       <= err_d;
        end
    end

    assign req_ready_o = ready_q;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_data_o  = rsp_data_q;
    assign rsp_err_o   = rsp_err_q;
    assign init_done_o = init_done_q;
    assign err_o       = err_q;
    assign spi_start_o = start_q;
    assign spi_wr_h_o  = wr_h_q;
    assign spi_wr_l_o  = wr_l_q;

endmodule
